add_accum: RTL
==============

# add_accum

Downstream consumer of the 4-bit operand adder. Takes the adder's 5-bit `sum` stream over a valid/ready handshake and accumulates `FRAME_LEN` consecutive samples into a frame total. It then presents the total, with an overflow flag, on a second valid/ready output and holds it until it is taken. It sits between the adder and the scoreboard/monitor logic, which consume per-frame totals instead of raw sums.

## Interface
Parameters:
- `SUM_W`, 5: width of the incoming adder sum (4-bit operands plus carry).
- `ACC_W`, 8: accumulator and output width; must be ≥ `SUM_W`.
- `FRAME_LEN`, 4: samples per frame; legal range 1..255.

Ports:
- `clk`  in  1  the single clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  `in_sum` is valid this cycle.
- `in_ready`  out  1  block accepts a sample this cycle.
- `in_sum`  in  `SUM_W`  adder result, unsigned.
- `out_valid`  out  1  frame total available.
- `out_ready`  in  1  consumer takes the total this cycle.
- `out_total`  out  `ACC_W`  frame total, unsigned.
- `out_ovf`  out  1  the frame total exceeded `ACC_W` bits; sticky per frame.

## Operation
- FSM has two states: ACCUM and HOLD. Reset state is ACCUM.
- In ACCUM:
  - `in_ready`=1 and `out_valid`=0.
  - A sample is accepted when `in_valid && in_ready`. The accumulator becomes acc + zero-extended `in_sum`, and the sample counter increments.
  - On acceptance with count == `FRAME_LEN`-1:
    - the final sum is loaded into the `out_total` register;
    - `out_ovf` is updated;
    - the FSM moves to HOLD.
- In HOLD:
  - `in_ready`=0 and `out_valid`=1.
  - `out_total` and `out_ovf` are stable.
  - On `out_ready`=1: accumulator, counter and `out_ovf` clear, and the FSM returns to ACCUM.
- Overflow is detected on each add via the carry out of bit `ACC_W`-1. `out_ovf` is sticky from the first overflowing add until the frame is released.
- `in_sum` is ignored whenever no acceptance occurs. `out_ready` is ignored in ACCUM.
- Accumulation is unsigned only; no rounding and no averaging.
- Reset mid-frame discards the partial accumulation. Reset during HOLD drops the pending total with no handshake.
- `FRAME_LEN`=1: every accepted sample goes directly to HOLD.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `out_total`=0, `out_ovf`=0;
  - internal accumulator and counter are 0.
- Latency: the final sample is accepted at edge N; `out_valid`=1 is visible after edge N, i.e. in cycle N+1.
- Release: `out_valid` falls and `in_ready` rises in the cycle after the `out_valid && out_ready` edge.
- Minimum frame period is `FRAME_LEN`+1 cycles, because the release cycle does not accept a sample.
- All outputs are registered or decoded from state only. There is no combinational path from `in_valid`/`out_ready` to `in_ready`/`out_valid`.
- The upstream source must hold `in_sum` stable while `in_valid`=1 and `in_ready`=0.

## Configuration
- Macro: `ADD_ACCUM_SAT_EN`.
- Defined: on overflow the accumulator clamps to 2^`ACC_W`-1 and stays clamped for the rest of the frame; `out_ovf`=1.
- Undefined: the accumulator wraps modulo 2^`ACC_W`; `out_ovf`=1 still flags the wrap.
- Port list and timing are identical in both builds.

## Structure
- Shared package `add_pkg`:
  - `SUM_W` default constant;
  - `acc_state_t` enum {ACCUM, HOLD};
  - frame-total struct {total, ovf} for the monitor.
- The `add_if` interface gains the handshake signals `in_valid`/`in_ready` alongside `sum`, so the adder and the accumulator share one bundle.
- One natural sub-module, `frame_counter`:
  - mod-`FRAME_LEN` counter with enable and clear;
  - `last` output asserted when count == `FRAME_LEN`-1.

## Test plan
- Basic frame: `FRAME_LEN`=4, `ACC_W`=8. Sums 8, 8, 7, 10 with `in_valid` held high and `out_ready`=1 → `out_total`=33, `out_ovf`=0, `out_valid` for one cycle, one cycle after the 4th acceptance.
- Backpressure: same stimulus with `out_ready`=0 for 5 cycles → `out_total`=33 held, `in_ready`=0 throughout. Then `out_ready`=1 → the next frame starts from 0.
- Gapped input: `in_valid` toggles 1,0,1,0 with sums 30, x, 30, x, 1, 2 → total 63; the idle-cycle sums are ignored.
- Overflow: `ACC_W`=6, `FRAME_LEN`=3, sums 30, 30, 30 → without the macro `out_total`=26 and `out_ovf`=1; with `ADD_ACCUM_SAT_EN`, `out_total`=63 and `out_ovf`=1.
- Reset mid-frame: accept 5, 5, assert `rst` for 1 cycle, then accept 1, 1, 1, 1 → `out_total`=4. All outputs read their reset values during `rst`.
- `FRAME_LEN`=1: sums 3, 4 back-to-back with `out_ready`=1 → totals 3 then 4, `in_ready` low every other cycle.

Source files
------------

// File: rtl/add_pkg.sv
// Shared types for the adder / frame-accumulator pair.
package add_pkg;

  localparam int DEF_SUM_W = 5;
  localparam int DEF_ACC_W = 8;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic [DEF_ACC_W-1:0] total;
    logic                 ovf;
  } frame_total_t;

endpackage

// File: rtl/add_accum_frame_counter.sv
// Mod-FRAME_LEN sample counter; clear wins over enable, last flags the final slot.
module frame_counter #(
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic last
);

  logic [CNT_W-1:0] cnt_q;

  assign last = (cnt_q == CNT_W'(FRAME_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/add_accum.sv
// Accumulates FRAME_LEN adder sums into a held frame total with overflow flag.
// ADD_ACCUM_SAT_EN: clamp the accumulator on overflow instead of wrapping.
//
// state | meaning
// ACCUM | accepting samples, building the frame total
// HOLD  | frame total presented, waiting for out_ready
module add_accum
  import add_pkg::*;
#(
  parameter int SUM_W     = DEF_SUM_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int FRAME_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_ovf
);

  acc_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_add;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic             accept;
  logic             release_f;
  logic             last;

  frame_counter #(
    .FRAME_LEN (FRAME_LEN)
  ) u_frame_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (accept),
    .clr  (release_f),
    .last (last)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    release_f = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && last) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        release_f = out_ready;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    sum_ext = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, in_sum};
    carry   = sum_ext[ACC_W];
`ifdef ADD_ACCUM_SAT_EN
    // out_ovf already set means the accumulator sits at full scale
    acc_add = (carry || out_ovf) ? '1 : sum_ext[ACC_W-1:0];
`else
    acc_add = sum_ext[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      out_total <= '0;
      out_ovf   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        acc_q <= acc_add;
        if (carry) out_ovf <= 1'b1;
        if (last)  out_total <= acc_add;
      end
      if (release_f) begin
        acc_q   <= '0;
        out_ovf <= 1'b0;
      end
    end
  end

endmodule
